// File: rtl/mandel_pixel_scheduler.sv
// Frame sequencer for the Mandelbrot engine array: raster-order job dispatch to the lowest
// idle engine, round-robin result collection, and the start/ready/ret handshake.
module mandel_pixel_scheduler #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned XW          = 8,
    parameter int unsigned YW          = 8,
    parameter int unsigned ITW         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       ready,
    output logic [31:0]                ret,
    output logic [NUM_ENGINES-1:0]     job_valid,
    input  logic [NUM_ENGINES-1:0]     job_ready,
    output logic [XW-1:0]              job_px,
    output logic [YW-1:0]              job_py,
    input  logic [NUM_ENGINES-1:0]     res_valid,
    input  logic [NUM_ENGINES*ITW-1:0] res_iters,
    output logic [NUM_ENGINES-1:0]     res_ack
);

    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned RW    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic [31:0]           r_ret;
    logic [XW-1:0]         r_px;
    logic [YW-1:0]         r_py;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_collected;
    logic [RW-1:0]         r_rr;

    logic [NUM_ENGINES-1:0] w_job_valid;
    logic                   w_job_fire;
    logic                   w_ack_any;
    logic [RW-1:0]          w_ack_idx;
    logic [ITW-1:0]         w_ack_iters;
    logic                   w_collecting;

    // Offer the job to the lowest-numbered idle engine (isolate lowest set bit).
    assign w_job_valid = (r_state == S_RUN) ? (job_ready & (~job_ready + NUM_ENGINES'(1))) : '0;
    assign w_job_fire  = |(w_job_valid & job_ready);

    assign w_collecting = (r_state == S_RUN) || (r_state == S_DRAIN);

    // Round-robin grant: descending scan so the engine nearest r_rr wins last.
    always_comb begin
        w_ack_any = 1'b0;
        w_ack_idx = '0;
        if (w_collecting) begin
            for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
                if (res_valid[(32'(r_rr) + 32'(k)) % NUM_ENGINES]) begin
                    w_ack_any = 1'b1;
                    w_ack_idx = RW'((32'(r_rr) + 32'(k)) % NUM_ENGINES);
                end
            end
        end
    end

    assign w_ack_iters = res_iters[32'(w_ack_idx) * ITW +: ITW];

    assign job_valid = w_job_valid;
    assign res_ack   = w_ack_any ? (NUM_ENGINES'(1) << w_ack_idx) : '0;
    assign job_px    = r_px;
    assign job_py    = r_py;
    assign ready     = r_ready;
    assign ret       = r_ret;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_ret       <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_issued    <= '0;
            r_collected <= '0;
            r_rr        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_px        <= '0;
                        r_py        <= '0;
                        r_issued    <= '0;
                        r_collected <= '0;
                        r_ret       <= '0;
                    end
                end
                S_RUN: begin
                    if (w_job_fire) begin
                        if (r_px == XW'(WIDTH - 1)) begin
                            r_px <= '0;
                            r_py <= r_py + YW'(1);
                        end else begin
                            r_px <= r_px + XW'(1);
                        end
                        r_issued <= r_issued + CW'(1);
                        if (r_issued == CW'(TOTAL - 1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_ack_any && (r_collected == CW'(TOTAL - 1))) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Result accumulation; the grant is already gated to RUN/DRAIN.
            if (w_ack_any) begin
                r_ret       <= r_ret + 32'(w_ack_iters);
                r_collected <= r_collected + CW'(1);
                r_rr        <= RW'((32'(w_ack_idx) + 32'd1) % NUM_ENGINES);
            end
        end
    end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler: behavioural engine array, job-order scoreboard,
// iteration-sum model, and directed round-robin / reset-in-drain sequences.
module tb_mandel_pixel_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned H     = 2;
    localparam int unsigned XW    = 3;
    localparam int unsigned YW    = 2;
    localparam int unsigned ITW   = 16;
    localparam int unsigned TOTAL = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start;
    logic               ready;
    logic [31:0]        ret;
    logic [N-1:0]       job_valid;
    logic [N-1:0]       job_ready;
    logic [XW-1:0]      job_px;
    logic [YW-1:0]      job_py;
    logic [N-1:0]       res_valid;
    logic [N*ITW-1:0]   res_iters;
    logic [N-1:0]       res_ack;

    mandel_pixel_scheduler #(
        .NUM_ENGINES(N), .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .ITW(ITW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .ret(ret),
        .job_valid(job_valid), .job_ready(job_ready), .job_px(job_px), .job_py(job_py),
        .res_valid(res_valid), .res_iters(res_iters), .res_ack(res_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Engine model state
    bit               auto_en;
    bit               rnd_allow;
    bit               rnd_iters;
    int               max_lat;
    logic [ITW-1:0]   cval;
    logic [N-1:0]     busy;
    logic [N-1:0]     hasres;
    int               tmr [N];
    logic [ITW-1:0]   val [N];

    // Values sampled just before the next active edge
    logic [N-1:0]     s_jv;
    logic [N-1:0]     s_ack;
    logic [XW-1:0]    s_px;
    logic [YW-1:0]    s_py;

    logic [XW+YW-1:0] exp_jobs [$];
    logic [31:0]      exp_sum;
    int               n_disp;

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest = N'(1) << i;
        end
    endfunction

    // One clock period: apply last edge's transfers to the engine model, drive, sample.
    task automatic cycle();
        logic             rst_pre;
        logic [N-1:0]     jr_pre;
        logic [ITW-1:0]   it;
        logic [XW+YW-1:0] e;
        rst_pre = reset;
        jr_pre  = job_ready;
        @(posedge clk);
        #1;
        if (auto_en) begin
            if (rst_pre) begin
                busy   = '0;
                hasres = '0;
            end else begin
                hasres = hasres & ~s_ack;
                for (int i = 0; i < N; i++) begin
                    if (s_jv[i] && jr_pre[i]) begin
                        it       = rnd_iters ? ITW'($urandom_range(0, 65535)) : cval;
                        busy[i]  = 1'b1;
                        tmr[i]   = (max_lat == 0) ? 0 : int'($urandom_range(0, max_lat));
                        val[i]   = it;
                        exp_sum  = exp_sum + 32'(it);
                        n_disp++;
                        if (exp_jobs.size() == 0) begin
                            check_eq("extra_job", 64'(n_disp), 64'(TOTAL));
                        end else begin
                            e = exp_jobs.pop_front();
                            check_eq("job_xy", 64'({s_px, s_py}), 64'(e));
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (busy[i]) begin
                        if (tmr[i] == 0) begin
                            busy[i]   = 1'b0;
                            hasres[i] = 1'b1;
                        end else begin
                            tmr[i]--;
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                job_ready[i] = !busy[i] && !hasres[i] && (!rnd_allow || ($urandom_range(0, 1) == 1));
                res_iters[i*ITW +: ITW] = val[i];
            end
            res_valid = hasres;
        end
        #1;
        s_jv  = job_valid;
        s_ack = res_ack;
        s_px  = job_px;
        s_py  = job_py;
        if (s_ack != '0) begin
            check_eq("ack_onehot", 64'($countones(s_ack)), 64'd1);
            if (auto_en) check_eq("ack_has_result", 64'(s_ack & ~hasres), 64'd0);
        end
        if (s_jv != '0) check_eq("jv_lowest", 64'(s_jv), 64'(lowest(job_ready)));
    endtask

    task automatic arm_frame();
        exp_jobs.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_jobs.push_back({XW'(x), YW'(y)});
        exp_sum = '0;
        n_disp  = 0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cycle();
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("frame_done", 64'(ok), 64'd1);
        check_eq("ret_sum", 64'(ret), 64'(exp_sum));
        check_eq("n_jobs", 64'(n_disp), 64'(TOTAL));
        check_eq("jobs_left", 64'(exp_jobs.size()), 64'd0);
    endtask

    logic [N-1:0] t3_valid [4];
    logic [N-1:0] t3_ack   [4];

    initial begin
        reset = 1'b1; start = 1'b1; job_ready = '0; res_valid = '0; res_iters = '0;
        auto_en = 1'b1; rnd_allow = 1'b0; rnd_iters = 1'b0; max_lat = 0; cval = 16'd5;
        busy = '0; hasres = '0;
        for (int i = 0; i < N; i++) begin tmr[i] = 0; val[i] = '0; end
        s_jv = '0; s_ack = '0; s_px = '0; s_py = '0;

        // Reset with start held high
        repeat (2) begin
            cycle();
            check_eq("rst_ready", 64'(ready), 64'd0);
            check_eq("rst_ret", 64'(ret), 64'd0);
            check_eq("rst_jv", 64'(s_jv), 64'd0);
        end

        // Constant iters=5, engines always ready
        arm_frame();
        reset = 1'b0;
        wait_done();
        check_eq("ret_40", 64'(ret), 64'd40);

        // start held after DONE: no new frame
        repeat (4) begin
            cycle();
            check_eq("done_hold_ready", 64'(ready), 64'd1);
            check_eq("done_hold_jv", 64'(s_jv), 64'd0);
            check_eq("done_hold_ret", 64'(ret), 64'd40);
        end
        start = 1'b0;
        cycle();
        check_eq("idle_ready", 64'(ready), 64'd0);
        check_eq("idle_ret_kept", 64'(ret), 64'd40);

        // Restart with random iters, latency and readiness
        rnd_iters = 1'b1; rnd_allow = 1'b1; max_lat = 3;
        cycle();
        arm_frame();
        start = 1'b1;
        cycle();
        check_eq("ret_clear_on_run", 64'(ret), 64'd0);
        wait_done();
        start = 1'b0;
        cycle();

        // Max iteration counts: sum must not truncate
        rnd_iters = 1'b0; rnd_allow = 1'b0; max_lat = 1; cval = 16'hFFFF;
        arm_frame();
        start = 1'b1;
        wait_done();
        check_eq("ret_ffff", 64'(ret), 64'(TOTAL * 65535));
        start = 1'b0;
        cycle();

        // Round-robin order with all four valid and rr=2
        auto_en = 1'b0;
        job_ready = '0; res_valid = '0;
        res_iters = {16'd4, 16'd3, 16'd2, 16'd1};
        reset = 1'b1; cycle(); reset = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        res_valid = 4'b0010;
        #1 check_eq("rr_setup", 64'(res_ack), 64'b0010);
        cycle();
        t3_valid[0] = 4'b1111; t3_ack[0] = 4'b0100;
        t3_valid[1] = 4'b1011; t3_ack[1] = 4'b1000;
        t3_valid[2] = 4'b0011; t3_ack[2] = 4'b0001;
        t3_valid[3] = 4'b0010; t3_ack[3] = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            res_valid = t3_valid[k];
            #1 check_eq("rr_order", 64'(res_ack), 64'(t3_ack[k]));
            cycle();
        end
        res_valid = '0;
        check_eq("rr_sum", 64'(ret), 64'd12);

        // Reset while draining with three results pending
        reset = 1'b1; cycle(); reset = 1'b0;
        job_ready = '1;
        start = 1'b1; cycle(); start = 1'b0;
        for (int k = 0; k < int'(TOTAL); k++) begin
            check_eq("drain_jv", 64'(s_jv), 64'b0001);
            check_eq("drain_xy", 64'({s_px, s_py}), 64'({XW'(k % W), YW'(k / W)}));
            cycle();
        end
        check_eq("drain_no_job", 64'(s_jv), 64'd0);
        res_valid = 4'b0111;
        #1 check_eq("drain_collect", 64'(res_ack), 64'b0001);
        reset = 1'b1;
        cycle();
        check_eq("rst_drain_ack", 64'(s_ack), 64'd0);
        check_eq("rst_drain_ready", 64'(ready), 64'd0);
        check_eq("rst_drain_jv", 64'(s_jv), 64'd0);
        check_eq("rst_drain_ret", 64'(ret), 64'd0);
        reset = 1'b0; res_valid = '0; job_ready = '0;
        busy = '0; hasres = '0;
        auto_en = 1'b1; rnd_iters = 1'b1; rnd_allow = 1'b1; max_lat = 2;
        cycle();
        arm_frame();
        start = 1'b1;
        wait_done();
        start = 1'b0;
        cycle();
        check_eq("final_idle", 64'(ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
